// File: rtl/id_stage.sv
// Decode stage: IF/ID and ID/EX pipeline registers, 32-entry register file,
// main decoder, ID-resolved beq/bne/j and load-use / branch-operand stall.
module id_stage #(
  parameter logic [31:0] NOP_INST = 32'h0000_0000,
  parameter int          RF_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc4,
  input  logic [31:0] if_inst,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_we,
  input  logic        ex_mem_read,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        stall,
  output logic        ctrl_branch,
  output logic [31:0] nid_pc,
  output logic [31:0] ex_pc4,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_shamt,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_dst,
  output logic [3:0]  ex_alu_op,
  output logic        ex_alu_src,
  output logic        ex_reg_we_o,
  output logic        ex_mem_read_o,
  output logic        ex_mem_write
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FUNC_SLL = 6'b000000;
  localparam logic [5:0] FUNC_SRL = 6'b000010;
  localparam logic [5:0] FUNC_SRA = 6'b000011;
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_NOR = 6'b100111;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  // addi/andi/ori reuse the ADD/AND/OR codes; ex_alu_src selects the immediate.
  localparam logic [3:0] INST_TYPE_NONE = 4'd0;
  localparam logic [3:0] INST_TYPE_ADD  = 4'd1;
  localparam logic [3:0] INST_TYPE_SUB  = 4'd2;
  localparam logic [3:0] INST_TYPE_AND  = 4'd3;
  localparam logic [3:0] INST_TYPE_OR   = 4'd4;
  localparam logic [3:0] INST_TYPE_NOR  = 4'd5;
  localparam logic [3:0] INST_TYPE_SLT  = 4'd6;
  localparam logic [3:0] INST_TYPE_SLL  = 4'd7;
  localparam logic [3:0] INST_TYPE_SRL  = 4'd8;
  localparam logic [3:0] INST_TYPE_SRA  = 4'd9;
  localparam logic [3:0] INST_TYPE_LW   = 4'd10;
  localparam logic [3:0] INST_TYPE_SW   = 4'd11;
  localparam logic [3:0] INST_TYPE_BEQ  = 4'd12;
  localparam logic [3:0] INST_TYPE_BNE  = 4'd13;
  localparam logic [3:0] INST_TYPE_J    = 4'd14;

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  logic [31:0] ifid_inst_p0;
  logic [31:0] ifid_pc4_p0;
  logic [31:0] rf [RF_DEPTH];

  logic [5:0]  opcode, func;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;

  assign opcode = ifid_inst_p0[31:26];
  assign rs     = ifid_inst_p0[25:21];
  assign rt     = ifid_inst_p0[20:16];
  assign rd     = ifid_inst_p0[15:11];
  assign shamt  = ifid_inst_p0[10:6];
  assign func   = ifid_inst_p0[5:0];
  assign imm16  = ifid_inst_p0[15:0];

  logic [3:0]  dec_op;
  logic [4:0]  dec_dst;
  logic        dec_we, dec_mr, dec_mw, dec_src, dec_zext;
  logic        use_rs, use_rt, is_beq, is_bne, is_j;

  always_comb begin
    dec_op   = INST_TYPE_NONE;
    dec_dst  = rt;
    dec_we   = 1'b0;
    dec_mr   = 1'b0;
    dec_mw   = 1'b0;
    dec_src  = 1'b0;
    dec_zext = 1'b0;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    case (opcode)
      OP_R: begin
        dec_dst = rd;
        dec_we  = 1'b1;
        use_rs  = 1'b1;
        use_rt  = 1'b1;
        case (func)
          FUNC_ADD: dec_op = INST_TYPE_ADD;
          FUNC_SUB: dec_op = INST_TYPE_SUB;
          FUNC_AND: dec_op = INST_TYPE_AND;
          FUNC_OR:  dec_op = INST_TYPE_OR;
          FUNC_NOR: dec_op = INST_TYPE_NOR;
          FUNC_SLT: dec_op = INST_TYPE_SLT;
          FUNC_SLL: begin dec_op = INST_TYPE_SLL; use_rs = 1'b0; end
          FUNC_SRL: begin dec_op = INST_TYPE_SRL; use_rs = 1'b0; end
          FUNC_SRA: begin dec_op = INST_TYPE_SRA; use_rs = 1'b0; end
          default: begin
            dec_we = 1'b0;
            use_rs = 1'b0;
            use_rt = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin dec_op = INST_TYPE_ADD; dec_we = 1'b1; dec_src = 1'b1; use_rs = 1'b1; end
      OP_ANDI: begin
        dec_op = INST_TYPE_AND; dec_we = 1'b1; dec_src = 1'b1; dec_zext = 1'b1; use_rs = 1'b1;
      end
      OP_ORI: begin
        dec_op = INST_TYPE_OR; dec_we = 1'b1; dec_src = 1'b1; dec_zext = 1'b1; use_rs = 1'b1;
      end
      OP_LW: begin
        dec_op = INST_TYPE_LW; dec_we = 1'b1; dec_mr = 1'b1; dec_src = 1'b1; use_rs = 1'b1;
      end
      OP_SW: begin
        dec_op = INST_TYPE_SW; dec_mw = 1'b1; dec_src = 1'b1; use_rs = 1'b1; use_rt = 1'b1;
      end
      OP_BEQ: begin dec_op = INST_TYPE_BEQ; use_rs = 1'b1; use_rt = 1'b1; is_beq = 1'b1; end
      OP_BNE: begin dec_op = INST_TYPE_BNE; use_rs = 1'b1; use_rt = 1'b1; is_bne = 1'b1; end
      OP_J:   begin dec_op = INST_TYPE_J; is_j = 1'b1; end
      default: ;
    endcase
  end

  logic signed [31:0] imm_sext;
  logic [31:0]        dec_imm;

  assign imm_sext = sext16(imm16);
  assign dec_imm  = dec_zext ? {16'h0000, imm16} : $unsigned(imm_sext);

  // Register file read with same-cycle WB bypass; r0 is always zero.
  logic [31:0] rs_data, rt_data;

  always_comb begin
    rs_data = 32'h0;
    rt_data = 32'h0;
    if (rs != 5'd0) rs_data = (wb_we && wb_rd == rs) ? wb_data : rf[rs];
    if (rt != 5'd0) rt_data = (wb_we && wb_rd == rt) ? wb_data : rf[rt];
  end

  always_ff @(posedge clk) begin
    if (wb_we && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
  end

  logic ld_hit, br_hit, taken;
  logic signed [31:0] br_off;
  logic [31:0] br_target, j_target;

  assign ld_hit = ex_mem_read && ((use_rs && rs == ex_rd) || (use_rt && rt == ex_rd));
  assign br_hit = (is_beq || is_bne) && (rs == ex_rd || rt == ex_rd);
  assign stall  = ex_reg_we && (ex_rd != 5'd0) && (ld_hit || br_hit);

  assign br_off    = imm_sext <<< 2;
  assign br_target = ifid_pc4_p0 + $unsigned(br_off);
  assign j_target  = {ifid_pc4_p0[31:28], ifid_inst_p0[25:0], 2'b00};

  assign taken       = (is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data) || is_j;
  assign ctrl_branch = taken && !stall;
  assign nid_pc      = !ctrl_branch ? ifid_pc4_p0 : (is_j ? j_target : br_target);

  // IF/ID stage boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      ifid_inst_p0 <= NOP_INST;
      ifid_pc4_p0  <= 32'h0;
    end else if (!stall) begin
      if (ctrl_branch) begin
        ifid_inst_p0 <= NOP_INST;
        ifid_pc4_p0  <= 32'h0;
      end else begin
        ifid_inst_p0 <= if_inst;
        ifid_pc4_p0  <= if_pc4;
      end
    end
  end

  // ID/EX stage boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_pc4        <= 32'h0;
      ex_rs_data    <= 32'h0;
      ex_rt_data    <= 32'h0;
      ex_imm        <= 32'h0;
      ex_shamt      <= 5'd0;
      ex_rs         <= 5'd0;
      ex_rt         <= 5'd0;
      ex_dst        <= 5'd0;
      ex_alu_op     <= INST_TYPE_NONE;
      ex_alu_src    <= 1'b0;
      ex_reg_we_o   <= 1'b0;
      ex_mem_read_o <= 1'b0;
      ex_mem_write  <= 1'b0;
    end else begin
      ex_pc4        <= ifid_pc4_p0;
      ex_rs_data    <= rs_data;
      ex_rt_data    <= rt_data;
      ex_imm        <= dec_imm;
      ex_shamt      <= shamt;
      ex_rs         <= rs;
      ex_rt         <= rt;
      ex_dst        <= dec_dst;
      ex_alu_op     <= stall ? INST_TYPE_NONE : dec_op;
      ex_alu_src    <= stall ? 1'b0 : dec_src;
      ex_reg_we_o   <= stall ? 1'b0 : dec_we;
      ex_mem_read_o <= stall ? 1'b0 : dec_mr;
      ex_mem_write  <= stall ? 1'b0 : dec_mw;
    end
  end

endmodule
